// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adder_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default operand width
  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_bit_cell.sv
// One-bit gate-level full adder cell.
// Latency: purely combinational.
// Backpressure: none.
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic ab_x;

  // Sum and carry built from XOR/AND/OR gates
  assign ab_x  = a ^ b;
  assign sum   = ab_x ^ cin;
  assign carry = (a & b) | (ab_x & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped LSB first over WIDTH cycles.
// Latency: done pulses WIDTH cycles after the accepting edge; busy for WIDTH cycles.
// Backpressure: start is honoured only in IDLE; requests during RUN/DONE are dropped.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the WIDTH-1 sum bits produced so far; the final bit joins at the last slot
  logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_sum, fa_carry;
  logic             last_slot;
  logic [WIDTH-1:0] sum_cat;

  fa_bit_cell u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign last_slot = (cnt_q == CNT_W'(WIDTH - 1));
  assign sum_cat   = {fa_sum, sum_sh_q};

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      c_msb_q  <= c_msb_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state: accept in IDLE, step WIDTH slots, one DONE cycle, back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_slot) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift one slot per RUN cycle, publish result on the last slot
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    c_msb_d  = c_msb_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sh_d = '0;
        end
      end
      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_sh_d = sum_cat[WIDTH-1:1];
        carry_d  = fa_carry;
        cnt_d    = cnt_q + CNT_W'(1);
        // Carry out of slot WIDTH-2 is the carry into the MSB, needed for signed overflow
        if (cnt_q == CNT_W'(WIDTH - 2)) c_msb_d = fa_carry;
        if (last_slot) begin
          sum_d  = sum_cat;
          cout_d = fa_carry;
          ovf_d  = c_msb_q ^ fa_carry;
        end
      end
      default: ;
    endcase
  end

  // Outputs: status decoded from state, results from held registers
  always_comb begin
    busy     = (state_q == RUN);
    done     = (state_q == DONE);
    sum      = sum_q;
    cout     = cout_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8): directed table, corner sequences, random soak.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: start only raised when the DUT is known to be idle, except in the soak.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout, overflow;
  logic [W-1:0] sum;

  int pass_cnt = 0;
  int total_cnt = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain unsigned and signed integer arithmetic -> {cout, overflow, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    int           us;
    int           sv;
    logic [W:0]   t;
    logic         ov;
    us = int'(x) + int'(y) + int'(c);
    t  = (W+1)'(us);
    sv = int'($signed(x)) + int'($signed(y)) + int'(c);
    ov = (sv > 127) || (sv < -128);
    return {t[W], ov, t[W-1:0]};
  endfunction

  // Issue one job from IDLE; scramble inputs after acceptance; optionally re-pulse start at slot k
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        input int repulse_at,
                        output logic [W-1:0] osum, output logic ocout, output logic oovf,
                        output int lat, output int busy_n, output int done_n);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = -1; busy_n = 0; done_n = 0;
    osum = '0; ocout = 1'b0; oovf = 1'b0;
    for (int k = 0; k < 3 * W; k++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) begin
          lat = k; osum = sum; ocout = cout; oovf = overflow;
        end
      end
      if (k == repulse_at) begin
        start = 1'b1; a = 8'h11;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  vec_t         vecs[6];
  logic [W-1:0] r_sum;
  logic         r_cout, r_ovf;
  int           lat, busy_n, done_n;

  initial begin
    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};

    // Reset state
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, cout, overflow, sum}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", {busy, done}, '0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, -1, r_sum, r_cout, r_ovf, lat, busy_n, done_n);
      check($sformatf("vec%0d_sum", i), 32'(r_sum), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout_ovf", i), {r_cout, r_ovf}, {vecs[i].exp_cout, vecs[i].exp_ovf});
      check($sformatf("vec%0d_latency", i), lat, W);
      check($sformatf("vec%0d_busy_cycles", i), busy_n, W);
      check($sformatf("vec%0d_done_count", i), done_n, 1);
      check($sformatf("vec%0d_result_held", i), {cout, overflow, sum},
            {vecs[i].exp_cout, vecs[i].exp_ovf, vecs[i].exp_sum});
    end

    // Start re-pulsed with different operand mid-job is ignored
    run_op(8'h22, 8'h22, 1'b0, 3, r_sum, r_cout, r_ovf, lat, busy_n, done_n);
    check("repulse_sum", 32'(r_sum), 32'h44);
    check("repulse_single_done", done_n, 1);
    check("repulse_busy_cycles", busy_n, W);

    // Mid-operation async reset: outputs clear without an edge, job aborted
    run_op(8'h90, 8'h90, 1'b0, -1, r_sum, r_cout, r_ovf, lat, busy_n, done_n);
    check("pre_reset_result", {r_cout, r_ovf, r_sum}, model(8'h90, 8'h90, 1'b0));
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_reset_clear", {busy, done, cout, overflow, sum}, '0);
    @(negedge clk);
    rst = 1'b0;
    done_n = 0; busy_n = 0;
    for (int k = 0; k < 3 * W; k++) begin
      @(negedge clk);
      if (done) done_n++;
      if (busy) busy_n++;
    end
    check("no_done_after_reset", done_n, 0);
    check("no_busy_after_reset", busy_n, 0);
    run_op(8'hA5, 8'h3C, 1'b1, -1, r_sum, r_cout, r_ovf, lat, busy_n, done_n);
    check("post_reset_result", {r_cout, r_ovf, r_sum}, model(8'hA5, 8'h3C, 1'b1));
    check("post_reset_latency", lat, W);

    // Random soak with start held high
    begin
      logic [W+1:0] exp_q[$];
      int cyc = 0, last_acc = -1, n_acc = 0, n_done = 0;
      logic prev_busy;
      prev_busy = busy;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'b1;
      while (n_done < 1000 && cyc < 12000) begin
        @(negedge clk);
        cyc++;
        if (busy && !prev_busy) begin
          exp_q.push_back(model(a, b, cin));
          if (last_acc >= 0) check("soak_accept_interval", cyc - last_acc, W + 2);
          last_acc = cyc;
          n_acc++;
          if (n_acc >= 1000) start = 1'b0;
          a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
        if (done) begin
          check("soak_job_pending", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("soak_result", {cout, overflow, sum}, exp_q.pop_front());
          n_done++;
        end
        prev_busy = busy;
      end
      check("soak_jobs_completed", n_done, 1000);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
